// File: rtl/ram4kb.sv
`default_nettype none
// ============================================================================
// Module      : ram4kb
// Description : Single-port synchronous scratch RAM, DEPTH x DATA_W
//               (2048 x 16 = 4 KB by default). It accepts one request per
//               clock with no backpressure. The ready/error/rdata response
//               is registered and appears one cycle after the request.
//               Addresses at or above DEPTH return an error. They do not
//               alias onto the array.
// Ports       : clk    - clock, all state updates on the rising edge
//               rst    - asynchronous, active-low reset (clears outputs only)
//               addr   - word address of the request (ADDR_W bits)
//               wdata  - write data, used when write=1
//               write  - 1 = write, 0 = read; qualified by valid
//               valid  - request strobe, sampled on every rising edge
//               rdata  - registered read data
//               error  - registered, previous request was out of range
//               ready  - registered, previous request has completed
// Revision    : 1.0 - initial release
// ============================================================================
module ram4kb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              write,
    input  logic              valid,
    output logic [DATA_W-1:0] rdata,
    output logic              error,
    output logic              ready
);

    localparam int c_idx_w = $clog2(DEPTH);

    // The comparison is one bit wider than the address. This keeps it exact
    // even when DEPTH equals 2**ADDR_W.
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0]  r_rdata;
    logic               r_error;
    logic               r_ready;

    logic               w_in_range;
    logic [c_idx_w-1:0] w_idx;
    logic               w_do_write;

    // The full address is range-checked. Only the low bits index the array,
    // so an out-of-range address never touches memory.
    assign w_in_range = ({1'b0, addr} < c_depth);
    assign w_idx      = addr[c_idx_w-1:0];
    assign w_do_write = valid && write && w_in_range;

    // The array has no reset, so its contents survive a reset pulse. The
    // rst term blocks writes on edges that occur while reset is held, so
    // those requests are dropped.
    always_ff @(posedge clk) begin
        if (rst && w_do_write) begin
            r_mem[w_idx] <= wdata;
        end
    end

    // Response registers clear asynchronously. A write leaves rdata
    // untouched. An out-of-range access forces rdata to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
            r_error <= 1'b0;
            r_ready <= 1'b0;
        end else if (valid) begin
            r_ready <= 1'b1;
            if (w_in_range) begin
                r_error <= 1'b0;
                if (!write) begin
                    r_rdata <= r_mem[w_idx];
                end
            end else begin
                r_error <= 1'b1;
                r_rdata <= '0;
            end
        end else begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end
    end

    assign rdata = r_rdata;
    assign error = r_error;
    assign ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_ram4kb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram4kb
// Description : Self-checking bench for ram4kb. It uses a table of directed
//               vectors, hand-written reset sequences and random traffic.
//               The random traffic is checked against an associative-array
//               memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram4kb;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        write;
    logic        valid;
    logic [15:0] rdata;
    logic        error;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    ram4kb #(
        .DATA_W(16),
        .ADDR_W(16),
        .DEPTH (2048)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .wdata(wdata),
        .write(write),
        .valid(valid),
        .rdata(rdata),
        .error(error),
        .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a sparse word store plus the expected response.
    // ------------------------------------------------------------------
    logic [15:0] model_mem [int];
    logic [15:0] exp_rdata;
    logic        exp_ready;
    logic        exp_error;
    logic        exp_known;   // 0 when rdata comes from a never-written word

    task automatic model_reset();
        exp_rdata = 16'h0000;
        exp_ready = 1'b0;
        exp_error = 1'b0;
        exp_known = 1'b1;
    endtask

    task automatic model_step(input logic v, input logic w,
                              input logic [15:0] a, input logic [15:0] d);
        int ia;
        ia = int'(a);
        if (!v) begin
            exp_ready = 1'b0;
            exp_error = 1'b0;
        end else if (ia >= 2048) begin
            exp_ready = 1'b1;
            exp_error = 1'b1;
            exp_rdata = 16'h0000;
            exp_known = 1'b1;
        end else begin
            exp_ready = 1'b1;
            exp_error = 1'b0;
            if (w) begin
                model_mem[ia] = d;
            end else if (model_mem.exists(ia)) begin
                exp_rdata = model_mem[ia];
                exp_known = 1'b1;
            end else begin
                exp_known = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input logic er, input logic ee,
                         input logic [15:0] erd, input logic chk_rd);
        checks++;
        if (ready !== er || error !== ee || (chk_rd && rdata !== erd)) begin
            failures++;
            $display("FAIL %s: got ready=%b error=%b rdata=%h, expected ready=%b error=%b rdata=%h%s",
                     name, ready, error, rdata, er, ee, erd, chk_rd ? "" : " (rdata unchecked)");
        end
    endtask

    task automatic check_model(input string name);
        check(name, exp_ready, exp_error, exp_rdata, exp_known);
    endtask

    // Drive one request, let one rising edge take it, then sample 1 ns later.
    task automatic drive(input logic v, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        valid = v;
        write = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        if (rst) model_step(v, w, a, d);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        string       name;
        logic        v;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        er;
        logic        ee;
        logic [15:0] erd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Contents assume the sweep has left mem[i] = i+1.
        vecs[0]  = '{"oor_write_2048",   1'b1, 1'b1, 16'h0800, 16'hBEEF, 1'b1, 1'b1, 16'h0000};
        vecs[1]  = '{"oor_read_ffff",    1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000};
        vecs[2]  = '{"noalias_read_0",   1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001};
        vecs[3]  = '{"oor_write_8005",   1'b1, 1'b1, 16'h8005, 16'hDEAD, 1'b1, 1'b1, 16'h0000};
        vecs[4]  = '{"noalias_read_5",   1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h0006};
        vecs[5]  = '{"raw_write_100",    1'b1, 1'b1, 16'd100,  16'hA5A5, 1'b1, 1'b0, 16'h0006};
        vecs[6]  = '{"raw_read_100",     1'b1, 1'b0, 16'd100,  16'h0000, 1'b1, 1'b0, 16'hA5A5};
        vecs[7]  = '{"idle_w_ignored",   1'b0, 1'b1, 16'd100,  16'h1111, 1'b0, 1'b0, 16'hA5A5};
        vecs[8]  = '{"idle_hold",        1'b0, 1'b0, 16'd3,    16'h0000, 1'b0, 1'b0, 16'hA5A5};
        vecs[9]  = '{"reread_100",       1'b1, 1'b0, 16'd100,  16'h0000, 1'b1, 1'b0, 16'hA5A5};
        vecs[10] = '{"read_top_2047",    1'b1, 1'b0, 16'd2047, 16'h0000, 1'b1, 1'b0, 16'h0800};
        vecs[11] = '{"oor_read_2048",    1'b1, 1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1, 16'h0000};
        vecs[12] = '{"idle_after_err",   1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b0, 16'h0000};
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        rst   = 1'b0;
        valid = 1'b0;
        write = 1'b0;
        addr  = 16'h0000;
        wdata = 16'h0000;
        model_reset();
        #2;

        // 1. Requests are dropped while reset is held.
        valid = 1'b1; write = 1'b1; addr = 16'd5; wdata = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold_%0d", i), 1'b0, 1'b0, 16'h0000, 1'b1);
        end
        rst   = 1'b1;
        valid = 1'b0;
        drive(1'b1, 1'b0, 16'd5, 16'h0000);
        checks++;
        if (ready !== 1'b1 || error !== 1'b0 || rdata === 16'h1234) begin
            failures++;
            $display("FAIL reset_write_dropped: got ready=%b error=%b rdata=%h, expected ready=1 error=0 rdata!=1234",
                     ready, error, rdata);
        end

        // 2. Full sweep: write then read back every word.
        for (int i = 0; i < 2048; i++) begin
            drive(1'b1, 1'b1, 16'(i), 16'(i + 1));
            check($sformatf("sweep_wr_%0d", i), 1'b1, 1'b0, 16'h0000, 1'b0);
        end
        for (int i = 0; i < 2048; i++) begin
            drive(1'b1, 1'b0, 16'(i), 16'h0000);
            check($sformatf("sweep_rd_%0d", i), 1'b1, 1'b0, 16'(i + 1), 1'b1);
        end

        // 3/4. Out of range, aliasing, read-after-write, idle.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d);
            check(vecs[i].name, vecs[i].er, vecs[i].ee, vecs[i].erd, 1'b1);
        end

        // 5. An asynchronous reset mid-cycle clears outputs and preserves memory.
        drive(1'b1, 1'b1, 16'd7, 16'h0777);
        check("t5_write_7", 1'b1, 1'b0, 16'h0000, 1'b1);
        valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("t5_async_clear", 1'b0, 1'b0, 16'h0000, 1'b1);
        valid = 1'b1; write = 1'b1; addr = 16'd7; wdata = 16'hFFFF;
        @(posedge clk);
        #1;
        check("t5_held_in_reset", 1'b0, 1'b0, 16'h0000, 1'b1);
        rst   = 1'b1;
        valid = 1'b0;
        drive(1'b1, 1'b0, 16'd7, 16'h0000);
        check("t5_read_7", 1'b1, 1'b0, 16'h0777, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic        v;
            logic        w;
            logic [15:0] a;
            logic [15:0] d;
            v = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            d = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       a = 16'($urandom);
                1:       a = 16'($urandom_range(2040, 2055));
                default: a = 16'($urandom_range(0, 31));
            endcase
            drive(v, w, a, d);
            check_model($sformatf("rand_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
